// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined AND/NAND reduction macro.
package gf180mcu_fd_sc_mcu7t5v0__andn_pkg;

    localparam int MODE_AND  = 0;
    localparam int MODE_NAND = 1;

    // Number of 4-input tree levels needed to reduce n bits to one, never less than one.
    function automatic int clog4(input int n);
        int l;
        int p;
        l = 0;
        p = 1;
        for (int k = 0; k < 8; k++) begin
            if (p < n) begin
                p = p * 4;
                l = l + 1;
            end
        end
        return (l < 1) ? 1 : l;
    endfunction

    // Per-lane bit count held by stage i: ceil(n / 4^(i+1)).
    // A negative i yields n itself, which is handy for describing the stage-0 input.
    function automatic int stage_width(input int n, input int i);
        int d;
        d = 1;
        for (int j = 0; j < 8; j++) begin
            if (j <= i) begin
                d = d * 4;
            end
        end
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe_if.sv
// Producer/consumer bundle for the reduction pipe.
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// a producer holding valid keeps its payload stable until it is taken, and
// ready may depend combinationally on the far side's ready.
interface gf180mcu_fd_sc_mcu7t5v0__andn_pipe_if #(
    parameter int N     = 8,
    parameter int LANES = 1
) ();
    logic [LANES*N-1:0] A;
    logic               IN_VALID;
    logic               IN_READY;
    logic [LANES-1:0]   Z;
    logic               OUT_VALID;
    logic               OUT_READY;

    // The side that feeds operands and consumes results.
    modport master (
        output A, IN_VALID, OUT_READY,
        input  IN_READY, Z, OUT_VALID
    );

    // The reduction pipe itself.
    modport slave (
        input  A, IN_VALID, OUT_READY,
        output IN_READY, Z, OUT_VALID
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_stage.sv
// One pipeline level: 4-input AND groups (partial group padded with 1s),
// a data register, a valid register and the stage enable.
module gf180mcu_fd_sc_mcu7t5v0__andn_stage
    import gf180mcu_fd_sc_mcu7t5v0__andn_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int LANES = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    input  logic [LANES*IN_W-1:0]             i_data,
    input  logic                              i_en_next,
    output logic                              o_en,
    output logic                              o_valid,
    output logic [LANES*stage_width(IN_W,0)-1:0] o_data
);
    localparam int OUT_W = stage_width(IN_W, 0);

    logic [LANES*OUT_W-1:0] w_and;
    logic [LANES*OUT_W-1:0] r_data;
    logic                   r_valid;

    // Group AND: every bit starts at 1, so a short final group is implicitly padded.
    always_comb begin
        w_and = '1;
        for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < IN_W; b++) begin
                w_and[k*OUT_W + b/4] = w_and[k*OUT_W + b/4] & i_data[k*IN_W + b];
            end
        end
    end

    // An empty stage always accepts, so bubbles collapse even when downstream is stalled.
    assign o_en = !r_valid || i_en_next;

    // Valid follows upstream whenever enabled; data only moves when a real beat arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_and;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// Pipelined LANES x N-input AND/NAND reduction with valid/ready flow control.
// One register per 4-ary tree level; inversion for NAND happens after the last level.
module gf180mcu_fd_sc_mcu7t5v0__andn_pipe
    import gf180mcu_fd_sc_mcu7t5v0__andn_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = 1,
    parameter int MODE  = MODE_AND
) (
`ifdef USE_POWER_PINS
    inout  wire                VDD,
    inout  wire                VSS,
`endif
    input  logic               CLK,
    input  logic               RST,
    input  logic [LANES*N-1:0] A,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [LANES-1:0]   Z,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);
    localparam int   LEVELS = clog4(N);
    localparam logic L_INV  = (MODE == MODE_NAND);

    // w_valid[i] feeds stage i, w_valid[LEVELS] is the last stage's valid.
    // w_en[i] is stage i's enable, w_en[LEVELS] is the consumer's ready.
    logic [LEVELS:0] w_valid;
    logic [LEVELS:0] w_en;

    assign w_valid[0]    = IN_VALID;
    assign w_en[LEVELS]  = OUT_READY;

    for (genvar i = 0; i < LEVELS; i++) begin : g_stage
        localparam int IN_W  = stage_width(N, i - 1);
        localparam int OUT_W = stage_width(N, i);

        logic [LANES*IN_W-1:0]  w_din;
        logic [LANES*OUT_W-1:0] w_dout;

        if (i == 0) begin : g_src
            assign w_din = A;
        end else begin : g_src
            assign w_din = g_stage[i-1].w_dout;
        end

        gf180mcu_fd_sc_mcu7t5v0__andn_stage #(
            .IN_W  (IN_W),
            .LANES (LANES)
        ) u_stage (
            .i_clk     (CLK),
            .i_rst     (RST),
            .i_valid   (w_valid[i]),
            .i_data    (w_din),
            .i_en_next (w_en[i+1]),
            .o_en      (w_en[i]),
            .o_valid   (w_valid[i+1]),
            .o_data    (w_dout)
        );
    end

    // Ready is forced low during reset so nothing is taken while state is being cleared.
    assign IN_READY  = w_en[0] && !RST;
    assign OUT_VALID = w_valid[LEVELS];
    assign Z         = g_stage[LEVELS-1].w_dout ^ {LANES{L_INV}};

`ifndef FUNCTIONAL
    specify
        (CLK => Z) = (1.0, 1.0);
        (CLK => OUT_VALID) = (1.0, 1.0);
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// Directed bench: an 8x2 AND pipe and a 5x1 NAND pipe side by side.
module tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__andn_pipe_if #(.N(8), .LANES(2)) if_a ();
    gf180mcu_fd_sc_mcu7t5v0__andn_pipe_if #(.N(5), .LANES(1)) if_b ();

    gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.N(8), .LANES(2), .MODE(0)) u_dut_a (
        .CLK       (clk),
        .RST       (rst),
        .A         (if_a.A),
        .IN_VALID  (if_a.IN_VALID),
        .IN_READY  (if_a.IN_READY),
        .Z         (if_a.Z),
        .OUT_VALID (if_a.OUT_VALID),
        .OUT_READY (if_a.OUT_READY)
    );

    gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.N(5), .LANES(1), .MODE(1)) u_dut_b (
        .CLK       (clk),
        .RST       (rst),
        .A         (if_b.A),
        .IN_VALID  (if_b.IN_VALID),
        .IN_READY  (if_b.IN_READY),
        .Z         (if_b.Z),
        .OUT_VALID (if_b.OUT_VALID),
        .OUT_READY (if_b.OUT_READY)
    );

    // ---------------- bookkeeping ----------------
    int total  = 0;
    int bad    = 0;
    int pops_a = 0;
    int pops_b = 0;
    logic [1:0] exp_a[$];
    logic [0:0] exp_b[$];

    typedef struct {
        logic [15:0] a;
        logic [1:0]  za;
        logic [4:0]  b;
        logic        zb;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] a);
        if_a.IN_VALID = v;
        if_a.A        = a;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] b);
        if_b.IN_VALID = v;
        if_b.A        = b;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20; k++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            step();
        end
        chk({name, "_drain_a"}, exp_a.size(), 0);
        chk({name, "_drain_b"}, exp_b.size(), 0);
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (if_a.OUT_VALID && if_a.OUT_READY) begin
            pops_a++;
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_a_extra: actual=%b required=no output", if_a.Z);
            end else begin
                chk("sb_a_z", {30'd0, if_a.Z}, {30'd0, exp_a.pop_front()});
            end
        end
        if (if_b.OUT_VALID && if_b.OUT_READY) begin
            pops_b++;
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_b_extra: actual=%b required=no output", if_b.Z);
            end else begin
                chk("sb_b_z", {31'd0, if_b.Z}, {31'd0, exp_b.pop_front()});
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int p0;

        vecs[0] = '{16'hFEFF, 2'b01, 5'h1F, 1'b0};
        vecs[1] = '{16'hFFFF, 2'b11, 5'h0F, 1'b1};
        vecs[2] = '{16'h0000, 2'b00, 5'h10, 1'b1};
        vecs[3] = '{16'hFF00, 2'b10, 5'h00, 1'b1};
        vecs[4] = '{16'h7FFF, 2'b01, 5'h1F, 1'b0};
        vecs[5] = '{16'hFFFE, 2'b10, 5'h1E, 1'b1};
        vecs[6] = '{16'h8080, 2'b00, 5'h1F, 1'b0};
        vecs[7] = '{16'hFFEF, 2'b10, 5'h17, 1'b1};

        // 1. Reset with a transaction offered
        drive_a(1'b1, 16'hFFFF);
        drive_b(1'b1, 5'h1F);
        if_a.OUT_READY = 1'b1;
        if_b.OUT_READY = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        chk("rst_in_ready_a", if_a.IN_READY, 0);
        chk("rst_out_valid_a", if_a.OUT_VALID, 0);
        chk("rst_z_a", if_a.Z, 2'b00);
        chk("rst_in_ready_b", if_b.IN_READY, 0);
        chk("rst_out_valid_b", if_b.OUT_VALID, 0);
        chk("rst_z_b", if_b.Z, 1'b1);
        drive_a(1'b0, 16'h0000);
        drive_b(1'b0, 5'h00);
        rst = 1'b0;
        step();
        chk("rel_in_ready_a", if_a.IN_READY, 1);
        chk("rel_in_ready_b", if_b.IN_READY, 1);

        // 2. Streaming latency on the AND pipe
        drive_a(1'b1, 16'hFEFF); exp_a.push_back(2'b01);
        step();
        chk("str_ov_c1", if_a.OUT_VALID, 0);
        drive_a(1'b1, 16'hFFFF); exp_a.push_back(2'b11);
        step();
        chk("str_ov_c2", if_a.OUT_VALID, 1);
        chk("str_z_c2", if_a.Z, 2'b01);
        drive_a(1'b1, 16'h0000); exp_a.push_back(2'b00);
        step();
        chk("str_ov_c3", if_a.OUT_VALID, 1);
        chk("str_z_c3", if_a.Z, 2'b11);
        drive_a(1'b0, 16'h0000);
        step();
        chk("str_ov_c4", if_a.OUT_VALID, 1);
        chk("str_z_c4", if_a.Z, 2'b00);
        step();
        chk("str_ov_c5", if_a.OUT_VALID, 0);
        drain("str");

        // Table of vectors streamed into both pipes
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, vecs[i].a);
            drive_b(1'b1, vecs[i].b);
            chk("tbl_rdy_a", if_a.IN_READY, 1);
            chk("tbl_rdy_b", if_b.IN_READY, 1);
            exp_a.push_back(vecs[i].za);
            exp_b.push_back(vecs[i].zb);
            step();
        end
        drive_a(1'b0, 16'h0000);
        drive_b(1'b0, 5'h00);
        drain("tbl");

        // 3. Backpressure with a full pipe
        if_a.OUT_READY = 1'b0;
        drive_a(1'b1, 16'hFFFF); exp_a.push_back(2'b11);
        chk("bp_rdy1", if_a.IN_READY, 1);
        step();
        drive_a(1'b1, 16'h00FF); exp_a.push_back(2'b01);
        chk("bp_rdy2", if_a.IN_READY, 1);
        step();
        drive_a(1'b1, 16'hFF00);
        chk("bp_rdy3", if_a.IN_READY, 0);
        step();
        chk("bp_rdy3_hold", if_a.IN_READY, 0);
        chk("bp_ov_hold", if_a.OUT_VALID, 1);
        chk("bp_z_hold1", if_a.Z, 2'b11);
        step();
        chk("bp_z_hold2", if_a.Z, 2'b11);
        chk("bp_ov_hold2", if_a.OUT_VALID, 1);
        if_a.OUT_READY = 1'b1;
        #1;
        chk("bp_pushpop_rdy", if_a.IN_READY, 1);
        exp_a.push_back(2'b10);
        p0 = pops_a;
        step();
        drive_a(1'b0, 16'h0000);
        drain("bp");
        chk("bp_count", pops_a - p0, 3);

        // 4. Bubble collapse under stall
        if_a.OUT_READY = 1'b0;
        drive_a(1'b1, 16'hF0FF); exp_a.push_back(2'b01);
        step();
        drive_a(1'b0, 16'h0000);
        step();
        chk("bc_ov", if_a.OUT_VALID, 1);
        chk("bc_z", if_a.Z, 2'b01);
        chk("bc_rdy_bubble", if_a.IN_READY, 1);
        drive_a(1'b1, 16'hFFF7); exp_a.push_back(2'b10);
        step();
        drive_a(1'b0, 16'h0000);
        chk("bc_rdy_full", if_a.IN_READY, 0);
        chk("bc_z_hold", if_a.Z, 2'b01);
        p0 = pops_a;
        if_a.OUT_READY = 1'b1;
        drain("bc");
        chk("bc_count", pops_a - p0, 2);

        // 5. Reset pulse with two transactions in flight
        drive_a(1'b1, 16'hFFFF); exp_a.push_back(2'b11);
        step();
        drive_a(1'b1, 16'h0000); exp_a.push_back(2'b00);
        step();
        drive_a(1'b0, 16'h0000);
        chk("rm_ov_before", if_a.OUT_VALID, 1);
        #1 rst = 1'b1;
        #1;
        chk("rm_ov", if_a.OUT_VALID, 0);
        chk("rm_rdy", if_a.IN_READY, 0);
        chk("rm_z", if_a.Z, 2'b00);
        #1 rst = 1'b0;
        exp_a.delete();
        exp_b.delete();
        p0 = pops_a;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rm_ov_after", if_a.OUT_VALID, 0);
        end
        chk("rm_no_output", pops_a - p0, 0);
        chk("rm_rdy_after", if_a.IN_READY, 1);

        // 6. NAND with padding (N=5, two levels)
        drive_b(1'b1, 5'h1F); exp_b.push_back(1'b0);
        step();
        chk("nand_ov_c1", if_b.OUT_VALID, 0);
        drive_b(1'b1, 5'h0F); exp_b.push_back(1'b1);
        step();
        drive_b(1'b0, 5'h00);
        chk("nand_ov_c2", if_b.OUT_VALID, 1);
        chk("nand_z_1f", if_b.Z, 1'b0);
        step();
        chk("nand_ov_c3", if_b.OUT_VALID, 1);
        chk("nand_z_0f", if_b.Z, 1'b1);
        step();
        chk("nand_ov_c4", if_b.OUT_VALID, 0);
        drain("nand");

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
